ctrl_seq: RTL

Control sequencer for the bus-based accumulator computer. Sits directly downstream of the 4-bit sequence counter: consumes its count (T0..T15) together with the instruction register, latches the decoded opcode and indirect bit, and drives the common-bus select, register load/increment strobes, memory write, AC/E operation code and the counter clear. Holds the run flip-flop that gates the whole machine.

---
 rtl/ctrl_seq.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ctrl_seq.sv
// Control sequencer for the bus-based accumulator computer: decodes sc/ir into bus and strobe controls.
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to halt and flag illegal register-ref/I/O instructions.
module ctrl_seq #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          start,
    input  logic [3:0]    sc,
    input  logic [DW-1:0] ir,
    input  logic          dr_zero,
    input  logic          ac_zero,
    input  logic          ac_neg,
    input  logic          e_zero,
    output logic          run,
    output logic          sc_clr,
    output logic [2:0]    bus_sel,
    output logic          ld_ar,
    output logic          inr_ar,
    output logic          ld_pc,
    output logic          inr_pc,
    output logic          ld_ir,
    output logic          ld_dr,
    output logic          inr_dr,
    output logic          mem_wr,
    output logic [3:0]    ac_op,
    output logic          err
);
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [2:0] B_AR = 3'd1, B_PC = 3'd2, B_DR = 3'd3, B_AC = 3'd4, B_IR = 3'd5, B_MEM = 3'd7;
    localparam logic [2:0] OP_AND = 3'd0, OP_ADD = 3'd1, OP_LDA = 3'd2, OP_STA = 3'd3,
                           OP_BUN = 3'd4, OP_BSA = 3'd5, OP_ISZ = 3'd6, OP_REG = 3'd7;

    logic       run_q, run_d;
    logic [2:0] opc_q, opc_d;
    logic       ind_q, ind_d;
    logic       err_q, err_d;
    logic [11:0] rr;
    logic       rr_onehot;
    logic       halt, trap;

    assign rr        = ir[11:0];
    assign rr_onehot = (rr != 12'd0) && ((rr & (rr - 12'd1)) == 12'd0);

    always_comb begin
        run_d   = run_q;
        opc_d   = opc_q;
        ind_d   = ind_q;
        err_d   = err_q;
        sc_clr  = 1'b1;
        bus_sel = 3'd0;
        ld_ar   = 1'b0;
        inr_ar  = 1'b0;
        ld_pc   = 1'b0;
        inr_pc  = 1'b0;
        ld_ir   = 1'b0;
        ld_dr   = 1'b0;
        inr_dr  = 1'b0;
        mem_wr  = 1'b0;
        ac_op   = 4'd0;
        halt    = 1'b0;
        trap    = 1'b0;
        if (!run_q) begin
            if (start) run_d = 1'b1;
        end else begin
            sc_clr = 1'b0;
            case (sc)
                4'd0: begin bus_sel = B_PC; ld_ar = 1'b1; end
                4'd1: begin bus_sel = B_MEM; ld_ir = 1'b1; inr_pc = 1'b1; end
                4'd2: begin
                    bus_sel = B_IR;
                    ld_ar   = 1'b1;
                    opc_d   = ir[DW-2:DW-4];
                    ind_d   = ir[DW-1];
                end
                4'd3: begin
                    if (opc_q == OP_REG) begin
                        sc_clr = 1'b1;
                        if (ind_q) begin
                            trap = TRAP_EN;
                        end else if (TRAP_EN && !rr_onehot) begin
                            trap = 1'b1;
                        end else if (rr[11]) ac_op = 4'd4;
                        else if (rr[10]) ac_op = 4'd5;
                        else if (rr[9])  ac_op = 4'd6;
                        else if (rr[8])  ac_op = 4'd7;
                        else if (rr[7])  ac_op = 4'd8;
                        else if (rr[6])  ac_op = 4'd9;
                        else if (rr[5])  ac_op = 4'd10;
                        else if (rr[4])  inr_pc = !ac_neg && !ac_zero;
                        else if (rr[3])  inr_pc = ac_neg;
                        else if (rr[2])  inr_pc = ac_zero;
                        else if (rr[1])  inr_pc = e_zero;
                        else if (rr[0])  halt = 1'b1;
                    end else if (ind_q) begin
                        bus_sel = B_MEM;
                        ld_ar   = 1'b1;
                    end
                end
                default: begin
                    // T4 and later: memory-reference execute; anything past the last step just clears sc
                    sc_clr = 1'b1;
                    case (opc_q)
                        OP_AND, OP_ADD, OP_LDA: begin
                            if (sc == 4'd4) begin
                                sc_clr = 1'b0; bus_sel = B_MEM; ld_dr = 1'b1;
                            end else if (sc == 4'd5) begin
                                ac_op = 4'({1'b0, opc_q}) + 4'd1;
                            end
                        end
                        OP_STA: if (sc == 4'd4) begin bus_sel = B_AC; mem_wr = 1'b1; end
                        OP_BUN: if (sc == 4'd4) begin bus_sel = B_AR; ld_pc = 1'b1; end
                        OP_BSA: begin
                            if (sc == 4'd4) begin
                                sc_clr = 1'b0; bus_sel = B_PC; mem_wr = 1'b1; inr_ar = 1'b1;
                            end else if (sc == 4'd5) begin
                                bus_sel = B_AR; ld_pc = 1'b1;
                            end
                        end
                        OP_ISZ: begin
                            if (sc == 4'd4) begin
                                sc_clr = 1'b0; bus_sel = B_MEM; ld_dr = 1'b1;
                            end else if (sc == 4'd5) begin
                                sc_clr = 1'b0; inr_dr = 1'b1;
                            end else if (sc == 4'd6) begin
                                bus_sel = B_DR; mem_wr = 1'b1; inr_pc = dr_zero;
                            end
                        end
                        default: ;
                    endcase
                end
            endcase
            if (halt || trap) run_d = 1'b0;
            if (trap) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            run_q <= 1'b0;
            opc_q <= 3'd0;
            ind_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            run_q <= run_d;
            opc_q <= opc_d;
            ind_q <= ind_d;
            err_q <= err_d;
        end
    end

    assign run = run_q;
    assign err = err_q;
endmodule
